// File: rtl/proc_pkg.sv
// Shared processor definitions: opcodes, instruction field positions and fetch FSM encoding.
package proc_pkg;

    localparam int unsigned PC_W      = 8;
    localparam int unsigned OPC_MSB   = 15;
    localparam int unsigned OPC_LSB   = 12;
    localparam int unsigned OPC_W     = OPC_MSB - OPC_LSB + 1;
    localparam int unsigned OPERAND_W = 8;
    localparam int unsigned WDOG_W    = 8;

    localparam logic [OPC_W-1:0] OP_NOP  = 4'h0;
    localparam logic [OPC_W-1:0] OP_JMP  = 4'hA;
    localparam logic [OPC_W-1:0] OP_JZ   = 4'hB;
    localparam logic [OPC_W-1:0] OP_JNZ  = 4'hC;
    localparam logic [OPC_W-1:0] OP_HALT = 4'hF;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PC_UPD,
        ST_FETCH,
        ST_DECODE,
        ST_ISSUE,
        ST_WAIT_EXEC,
        ST_HALT,
        ST_ERROR
    } fetch_state_e;

endpackage

// File: rtl/fetch_sequencer_if.sv
// Fetch sequencer bus: PC/ROM side plus the execute-unit valid/ready handshake.
interface fetch_sequencer_if
    import proc_pkg::*;
#(
    parameter int unsigned INSTR_W = 16
);
    logic [PC_W-1:0]    pc_addr;
    logic [INSTR_W-1:0] rom_data;
    logic               zero_flag;
    logic               exec_ready;
    logic               exec_done;
    logic               pc_load;
    logic               pc_inc;
    logic [PC_W-1:0]    pc_target;
    logic [INSTR_W-1:0] ir;
    logic               instr_valid;
    logic               halted;
    logic               error;

    modport master (
        input  pc_addr, rom_data, zero_flag, exec_ready, exec_done,
        output pc_load, pc_inc, pc_target, ir, instr_valid, halted, error
    );

    modport slave (
        output pc_addr, rom_data, zero_flag, exec_ready, exec_done,
        input  pc_load, pc_inc, pc_target, ir, instr_valid, halted, error
    );
endinterface

// File: rtl/fetch_watchdog.sv
// Clearable cycle counter; tc_c flags the TIMEOUT-th enabled cycle since the last clear.
module fetch_watchdog #(
    parameter int unsigned TIMEOUT = 255,
    parameter int unsigned CNT_W   = 8
) (
    input  logic Clk,
    input  logic Reset,
    input  logic clr,
    input  logic en,
    output logic tc_c
);
    logic [CNT_W-1:0] count;

    always_ff @(posedge Clk) begin
        if (Reset || clr) begin
            count <= '0;
        end else if (en) begin
            count <= count + CNT_W'(1);
        end
    end

    assign tc_c = en && (count == CNT_W'(TIMEOUT - 1));
endmodule

// File: rtl/fetch_sequencer.sv
// Instruction-fetch controller: steps the PC, latches ROM words, resolves flow control
// locally and hands everything else to the execute unit, guarded by a watchdog.
module fetch_sequencer
    import proc_pkg::*;
#(
    parameter int unsigned     INSTR_W      = 16,
    parameter int unsigned     ROM_LAT      = 1,
    parameter logic [PC_W-1:0] RESTART_ADDR = 8'h00,
    parameter int unsigned     EXEC_TIMEOUT = 255
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              start,
    fetch_sequencer_if.master bus
);
    localparam int unsigned FETCH_CNT_W = $clog2(ROM_LAT + 2);

    fetch_state_e           state;
    logic [FETCH_CNT_W-1:0] fetch_cnt;
    logic [OPC_W-1:0]       opcode_c;
    logic                   flow_c;
    logic                   take_c;
    logic                   wd_clr_c;
    logic                   wd_en_c;
    logic                   wd_tc_c;

    assign opcode_c = bus.ir[OPC_MSB:OPC_LSB];
    assign wd_clr_c = (state == ST_ISSUE) && bus.exec_ready;
    assign wd_en_c  = (state == ST_WAIT_EXEC);

    // Flow-control opcodes are resolved here; take_c selects load over increment.
    always_comb begin
        flow_c = 1'b0;
        take_c = 1'b0;
        case (opcode_c)
            OP_NOP: flow_c = 1'b1;
            OP_JMP: begin flow_c = 1'b1; take_c = 1'b1;           end
            OP_JZ:  begin flow_c = 1'b1; take_c = bus.zero_flag;  end
            OP_JNZ: begin flow_c = 1'b1; take_c = !bus.zero_flag; end
            default: ;
        endcase
    end

    fetch_watchdog #(
        .TIMEOUT (EXEC_TIMEOUT),
        .CNT_W   (WDOG_W)
    ) u_wdog (
        .Clk   (Clk),
        .Reset (Reset),
        .clr   (wd_clr_c),
        .en    (wd_en_c),
        .tc_c  (wd_tc_c)
    );

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state           <= ST_IDLE;
            fetch_cnt       <= '0;
            bus.pc_load     <= 1'b0;
            bus.pc_inc      <= 1'b0;
            bus.pc_target   <= '0;
            bus.ir          <= '0;
            bus.instr_valid <= 1'b0;
            bus.halted      <= 1'b0;
            bus.error       <= 1'b0;
        end else begin
            // PC strobes are single-cycle pulses unless re-armed below.
            bus.pc_load <= 1'b0;
            bus.pc_inc  <= 1'b0;
            case (state)
                ST_IDLE, ST_HALT: begin
                    if (start) begin
                        bus.pc_load   <= 1'b1;
                        bus.pc_target <= RESTART_ADDR;
                        bus.halted    <= 1'b0;
                        state         <= ST_PC_UPD;
                    end
                end
                ST_PC_UPD: begin
                    fetch_cnt <= '0;
                    state     <= ST_FETCH;
                end
                ST_FETCH: begin
                    if (fetch_cnt == FETCH_CNT_W'(ROM_LAT)) begin
                        bus.ir <= bus.rom_data;
                        state  <= ST_DECODE;
                    end else begin
                        fetch_cnt <= fetch_cnt + FETCH_CNT_W'(1);
                    end
                end
                ST_DECODE: begin
                    if (opcode_c == OP_HALT) begin
                        bus.halted <= 1'b1;
                        state      <= ST_HALT;
                    end else if (flow_c) begin
                        if (take_c) begin
                            bus.pc_load   <= 1'b1;
                            bus.pc_target <= bus.ir[OPERAND_W-1:0];
                        end else begin
                            bus.pc_inc <= 1'b1;
                        end
                        state <= ST_PC_UPD;
                    end else begin
                        bus.instr_valid <= 1'b1;
                        state           <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    if (bus.exec_ready) begin
                        bus.instr_valid <= 1'b0;
                        state           <= ST_WAIT_EXEC;
                    end
                end
                ST_WAIT_EXEC: begin
                    // Completion in the terminal-count cycle beats the watchdog.
                    if (bus.exec_done) begin
                        bus.pc_inc <= 1'b1;
                        state      <= ST_PC_UPD;
                    end else if (wd_tc_c) begin
                        bus.error <= 1'b1;
                        state     <= ST_ERROR;
                    end
                end
                ST_ERROR: begin
                    bus.error <= 1'b1;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_fetch_sequencer.sv
// Scoreboard bench for fetch_sequencer: PC register, registered ROM and execute-unit stub.
module tb_fetch_sequencer;
    import proc_pkg::*;

    localparam int unsigned INSTR_W = 16;
    localparam int unsigned TMO     = 4;
    localparam int          K_LOAD  = 0;
    localparam int          K_INC   = 1;
    localparam int          K_ISSUE = 2;

    typedef struct {
        int          kind;
        logic [15:0] val;
    } ev_t;

    logic Clk   = 1'b0;
    logic Reset = 1'b1;
    logic start = 1'b0;
    always #5 Clk = ~Clk;

    fetch_sequencer_if #(.INSTR_W(INSTR_W)) bus ();

    fetch_sequencer #(
        .INSTR_W      (INSTR_W),
        .ROM_LAT      (1),
        .RESTART_ADDR (8'h00),
        .EXEC_TIMEOUT (TMO)
    ) dut (
        .Clk   (Clk),
        .Reset (Reset),
        .start (start),
        .bus   (bus)
    );

    logic [15:0] rom [256];
    logic [7:0]  pc = 8'h77;
    int          zf_mode = 0;
    logic        wrapped = 1'b0;
    int          total = 0;
    int          bad = 0;
    ev_t         sb[$];
    ev_t         mon_e;
    int          mon_k;
    logic [15:0] mon_v;
    logic        prev_load = 1'b0;
    logic        prev_inc = 1'b0;

    // PC register and one-cycle-latency ROM, as seen by the sequencer.
    assign bus.pc_addr = pc;
    always @(posedge Clk) begin
        bus.rom_data <= rom[pc];
        if (bus.pc_load)     pc <= bus.pc_target;
        else if (bus.pc_inc) pc <= pc + 8'd1;
    end

    assign bus.zero_flag = (zf_mode == 1) ? ((pc == 8'h01) || (pc == 8'h20)) :
                           (zf_mode == 2) ? wrapped : 1'b0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic push(input int kind, input logic [15:0] val);
        ev_t e;
        e.kind = kind;
        e.val  = val;
        sb.push_back(e);
    endtask

    // Monitor: every PC strobe and every handshake is matched against the scoreboard.
    always @(negedge Clk) begin
        if (!Reset) begin
            if (bus.pc_load || bus.pc_inc) begin
                check_eq("strobe_excl", 32'(bus.pc_load & bus.pc_inc), 32'(0));
                check_eq("strobe_1cyc", 32'((bus.pc_load & prev_load) | (bus.pc_inc & prev_inc)), 32'(0));
            end
            if (bus.pc_inc && pc == 8'hFF) wrapped = 1'b1;
            mon_k = -1;
            if (bus.pc_load) begin
                mon_k = K_LOAD;  mon_v = {8'h00, bus.pc_target};
            end else if (bus.pc_inc) begin
                mon_k = K_INC;   mon_v = {8'h00, pc};
            end else if (bus.instr_valid && bus.exec_ready) begin
                mon_k = K_ISSUE; mon_v = bus.ir;
            end
            if (mon_k >= 0) begin
                if (sb.size() == 0) begin
                    check_eq("sb_unexpected", 32'(mon_k), 32'hFF);
                end else begin
                    mon_e = sb.pop_front();
                    check_eq("sb_kind", 32'(mon_k), 32'(mon_e.kind));
                    check_eq("sb_val", 32'(mon_v), 32'(mon_e.val));
                end
            end
        end
        prev_load = bus.pc_load;
        prev_inc  = bus.pc_inc;
    end

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic do_reset();
        Reset = 1'b1;
        bus.exec_ready = 1'b0;
        bus.exec_done  = 1'b0;
        start = 1'b0;
        tick();
        check_eq("rst_outs", 32'({bus.pc_load, bus.pc_inc, bus.instr_valid, bus.halted, bus.error}), 32'(0));
        check_eq("rst_ir", 32'(bus.ir), 32'(0));
        check_eq("rst_target", 32'(bus.pc_target), 32'(0));
        check_eq("sb_leftover", 32'(sb.size()), 32'(0));
        sb.delete();
        wrapped = 1'b0;
        Reset = 1'b0;
    endtask

    task automatic rom_clear();
        for (int i = 0; i < 256; i++) rom[i] = 16'hF000;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_halted(input string tag, input logic [7:0] exp_pc);
        int n = 0;
        while (!bus.halted && n < 200) begin
            tick();
            n++;
        end
        check_eq(tag, 32'(bus.halted), 32'(1));
        check_eq({tag, "_pc"}, 32'(pc), 32'(exp_pc));
        check_eq({tag, "_sb"}, 32'(sb.size()), 32'(0));
    endtask

    task automatic wait_valid(input string tag);
        int n = 0;
        while (!bus.instr_valid && n < 50) begin
            tick();
            n++;
        end
        check_eq(tag, 32'(bus.instr_valid), 32'(1));
    endtask

    initial begin
        int cyc;
        bus.exec_ready = 1'b0;
        bus.exec_done  = 1'b0;
        rom_clear();
        do_reset();

        // NOP then HALT, with start-to-increment latency.
        rom[8'h00] = 16'h0000;
        push(K_LOAD, 16'h0000); push(K_INC, 16'h0000);
        start = 1'b1;
        tick();
        start = 1'b0;
        check_eq("start_load", 32'(bus.pc_load), 32'(1));
        cyc = 0;
        while (!bus.pc_inc && cyc < 20) begin
            tick();
            cyc++;
        end
        check_eq("nop_latency", 32'(cyc), 32'(4));
        wait_halted("nop_halt", 8'h01);

        // JMP 42h, restarted straight from HALT.
        rom_clear();
        rom[8'h00] = 16'hA042;
        push(K_LOAD, 16'h0000); push(K_LOAD, 16'h0042);
        pulse_start();
        check_eq("halt_exit", 32'(bus.halted), 32'(0));
        wait_halted("jmp_halt", 8'h42);
        check_eq("jmp_ir", 32'(bus.ir), 32'h0000F000);

        // JZ not taken / taken, JNZ taken / not taken.
        rom_clear();
        rom[8'h00] = 16'hB010; rom[8'h01] = 16'hB010;
        rom[8'h10] = 16'hC020; rom[8'h20] = 16'hC030;
        zf_mode = 1;
        push(K_LOAD, 16'h0000); push(K_INC, 16'h0000); push(K_LOAD, 16'h0010);
        push(K_LOAD, 16'h0020); push(K_INC, 16'h0020);
        pulse_start();
        wait_halted("branch_halt", 8'h21);
        zf_mode = 0;

        // Execute instruction: ready held off, exec_done during ISSUE ignored.
        do_reset();
        rom_clear();
        rom[8'h00] = 16'h3005;
        push(K_LOAD, 16'h0000); push(K_ISSUE, 16'h3005); push(K_INC, 16'h0000);
        pulse_start();
        wait_valid("issue_valid");
        for (int i = 0; i < 5; i++) begin
            check_eq("issue_hold_v", 32'(bus.instr_valid), 32'(1));
            check_eq("issue_hold_ir", 32'(bus.ir), 32'h00003005);
            bus.exec_done = (i == 2);
            tick();
        end
        bus.exec_done  = 1'b0;
        bus.exec_ready = 1'b1;
        tick();
        bus.exec_ready = 1'b0;
        check_eq("issue_drop", 32'(bus.instr_valid), 32'(0));
        tick();
        tick();
        check_eq("exec_wait_noinc", 32'(bus.pc_inc), 32'(0));
        bus.exec_done = 1'b1;
        tick();
        bus.exec_done = 1'b0;
        check_eq("exec_inc", 32'(bus.pc_inc), 32'(1));
        wait_halted("exec_halt", 8'h01);

        // Watchdog timeout, sticky ERROR, start ignored, reset recovers.
        do_reset();
        push(K_LOAD, 16'h0000); push(K_ISSUE, 16'h3005);
        pulse_start();
        wait_valid("wd_valid");
        bus.exec_ready = 1'b1;
        tick();
        bus.exec_ready = 1'b0;
        cyc = 0;
        while (!bus.error && cyc < 20) begin
            tick();
            cyc++;
        end
        check_eq("wd_latency", 32'(cyc), 32'(TMO));
        pulse_start();
        tick();
        check_eq("err_sticky", 32'({bus.error, bus.pc_load, bus.pc_inc, bus.halted}), 32'b1000);
        do_reset();
        check_eq("err_cleared", 32'(bus.error), 32'(0));

        // exec_done on the terminal-count cycle wins over the watchdog.
        push(K_LOAD, 16'h0000); push(K_ISSUE, 16'h3005); push(K_INC, 16'h0000);
        pulse_start();
        wait_valid("race_valid");
        bus.exec_ready = 1'b1;
        tick();
        bus.exec_ready = 1'b0;
        for (int i = 0; i < int'(TMO) - 1; i++) tick();
        bus.exec_done = 1'b1;
        tick();
        bus.exec_done = 1'b0;
        check_eq("race_noerr", 32'({bus.error, bus.pc_inc}), 32'b01);
        wait_halted("race_halt", 8'h01);

        // Reset while an instruction is offered.
        do_reset();
        push(K_LOAD, 16'h0000);
        pulse_start();
        wait_valid("rst_issue_valid");
        do_reset();

        // NOP at FFh wraps the PC to 00h and fetch carries on.
        rom_clear();
        rom[8'h00] = 16'hC0FF; rom[8'hFF] = 16'h0000;
        zf_mode = 2;
        push(K_LOAD, 16'h0000); push(K_LOAD, 16'h00FF);
        push(K_INC, 16'h00FF); push(K_INC, 16'h0000);
        pulse_start();
        wait_halted("wrap_halt", 8'h01);
        zf_mode = 0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
